bip_control: RTL and testbench
==============================

BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 The block SHALL have parameters: NBITS_PC, default 11, program counter and operand width; NBITS_OPC, default 5, opcode width; NBITS_I, default 16, instruction width; NBITS_CNT, default 16, cycle-counter width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports:
- i_clock  in  1  rising-edge clock.
- i_reset  in  1  asynchronous active-low reset.
- i_start  in  1  run request, level-sampled.
- i_Instruction  in  NBITS_I  program memory data; sync read, valid the cycle after o_PC.
- o_PC  out  NBITS_PC  program memory address.
- o_Addr  out  NBITS_PC  data memory address.
- o_RdRam  out  1  data memory read enable; sync read, data valid next cycle.
- o_WrRam  out  1  data memory write enable; write data is datapath o_InData.
- o_SelA  out  2  accumulator mux select.
- o_SelB  out  1  ALU operand-B select.
- o_WrAcc  out  1  accumulator write enable.
- o_Op  out  1  ALU operation.
- o_Operand  out  NBITS_PC  datapath immediate, sign-extended downstream.
- o_busy  out  1  high in FETCH, DECODE and EXEC.
- o_halted  out  1  high in HALT.
- o_ClkCount  out  NBITS_CNT  executed-cycle counter.

Function
REQ-004 The instruction format SHALL be: opcode = i_Instruction[15:11], operand = i_Instruction[10:0].
REQ-005 The opcodes SHALL be: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7; opcodes 8-31 SHALL execute as NOP.
REQ-006 The select encodings SHALL be: SelA 0=memory data, 1=immediate, 2=ALU, 3 unused and never driven; SelB 0=memory data, 1=immediate; Op 0=add, 1=subtract.
REQ-007 The FSM states SHALL be IDLE, FETCH, DECODE, EXEC and HALT.
REQ-008 The FSM transitions SHALL be:
- IDLE -> FETCH when i_start=1; the same edge clears PC and o_ClkCount.
- FETCH -> DECODE unconditionally.
- DECODE -> HALT if the opcode is HLT; otherwise DECODE -> EXEC.
- EXEC -> FETCH unconditionally; the same edge applies PC <= PC+1.
- HALT -> FETCH when i_start=1, with PC and o_ClkCount cleared; otherwise HALT holds.
REQ-009 i_start SHALL be ignored in FETCH, DECODE and EXEC.
REQ-010 Every non-HLT instruction SHALL take exactly 3 cycles; HLT SHALL take 2 cycles, leaving o_PC at the HLT address.
REQ-011 An instruction register SHALL capture i_Instruction on the DECODE->EXEC edge; all EXEC outputs SHALL derive from it.
REQ-012 In DECODE, for LD, ADD and SUB, the block SHALL drive o_RdRam=1 and o_Addr=operand, combinationally from i_Instruction.
REQ-013 In EXEC, for LD, ADD and SUB, the block SHALL hold o_RdRam=1 with the same o_Addr.
REQ-014 The EXEC controls SHALL be:
- LD: SelA=0, WrAcc=1.
- LDI: SelA=1, WrAcc=1, Operand=operand.
- ADD: SelA=2, SelB=0, Op=0, WrAcc=1.
- ADDI: as ADD with SelB=1 and Operand=operand.
- SUB and SUBI: as ADD and ADDI with Op=1.
- STO: SelA=2, SelB=1, Op=0, Operand=0 (mux output = ACC+0), WrAcc=0, WrRam=1, Addr=operand.
- NOP: default values.
REQ-015 The default outputs, held whenever REQ-012 to REQ-014 do not apply, SHALL be: SelA=2, SelB=0, Op=0, WrAcc=0, WrRam=0, RdRam=0, Operand=0, Addr=0.
REQ-016 o_WrAcc and o_WrRam SHALL each be a single-cycle pulse per instruction, never both high.
REQ-017 The PC SHALL wrap from 2^NBITS_PC-1 to 0 without error.
REQ-018 o_ClkCount SHALL increment on every clock edge while o_busy=1, and SHALL saturate at all-ones.
REQ-019 All outputs SHALL be registered or decoded from state and registers only, with no path from i_start to the outputs, except the DECODE-phase address path in REQ-012.

Reset
REQ-020 While i_reset=0, the block SHALL asynchronously force state=IDLE, PC=0, instruction register=0 and o_ClkCount=0, with all controls at the REQ-015 defaults and o_busy=o_halted=0.
REQ-021 Reset asserted mid-instruction SHALL abort the instruction with no write pulse issued after the reset edge.
REQ-022 The first run after reset release SHALL require i_start=1.

Structure
REQ-023 A shared package bip_pkg SHALL hold the opcode constants, the FSM state enum, and the SelA, SelB and Op encoding constants, for reuse by the datapath and top level.
REQ-024 The block SHALL contain one sub-module, pc_counter, implementing the PC register with synchronous clear, increment enable and wrap.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Program LDI 5; ADDI 3; STO 10; HLT, with i_start pulsed -> one WrRam pulse at Addr=10 with o_InData=8; o_halted=1 with o_PC=3 and o_ClkCount=11.
- Memory[7]=20, program LD 7; SUB 7; SUBI 1 -> RdRam high in DECODE and EXEC of each instruction; final ACC=0xFFFF.
- Opcode 12 (NOP) -> no WrAcc or WrRam pulse; PC advances by 1 in 3 cycles.
- PC preset to 2047 via a NOP-filled ROM -> PC wraps to 0 and execution continues.
- i_reset=0 asserted in the EXEC of a STO -> WrRam drops immediately and outputs return to defaults; after release, no run begins until i_start=1.
- i_start held high through execution, then pulsed in HALT -> restart from PC=0 with o_ClkCount cleared, and no mid-run restart occurs.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit and datapath: opcodes, FSM states,
// accumulator/ALU select codes.
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'd0;
  localparam logic [4:0] OPC_STO  = 5'd1;
  localparam logic [4:0] OPC_LD   = 5'd2;
  localparam logic [4:0] OPC_LDI  = 5'd3;
  localparam logic [4:0] OPC_ADD  = 5'd4;
  localparam logic [4:0] OPC_ADDI = 5'd5;
  localparam logic [4:0] OPC_SUB  = 5'd6;
  localparam logic [4:0] OPC_SUBI = 5'd7;

  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;
  localparam logic       SELB_MEM = 1'b0;
  localparam logic       SELB_IMM = 1'b1;
  localparam logic       OP_ADD   = 1'b0;
  localparam logic       OP_SUB   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  // Instructions whose operand addresses data memory for a read.
  function automatic logic is_mem_read(input logic [4:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

endpackage

// File: rtl/bip_control_if.sv
// Program-memory, data-memory and datapath-control bundle between the BIP
// control unit (master) and its datapath/memories (slave).
interface bip_control_if #(
  parameter int NBITS_PC = 11,
  parameter int NBITS_I  = 16
);
  logic [NBITS_I-1:0]  i_Instruction;
  logic [NBITS_PC-1:0] o_PC;
  logic [NBITS_PC-1:0] o_Addr;
  logic                o_RdRam;
  logic                o_WrRam;
  logic [1:0]          o_SelA;
  logic                o_SelB;
  logic                o_WrAcc;
  logic                o_Op;
  logic [NBITS_PC-1:0] o_Operand;

  modport master (
    input  i_Instruction,
    output o_PC, o_Addr, o_RdRam, o_WrRam, o_SelA, o_SelB, o_WrAcc, o_Op, o_Operand
  );

  modport slave (
    output i_Instruction,
    input  o_PC, o_Addr, o_RdRam, o_WrRam, o_SelA, o_SelB, o_WrAcc, o_Op, o_Operand
  );
endinterface

// File: rtl/bip_control_pc_counter.sv
// Program counter: synchronous clear, increment enable, natural wrap at all-ones.
module pc_counter #(
  parameter int NBITS_PC = 11
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_clr,
  input  logic                i_inc,
  output logic [NBITS_PC-1:0] o_pc
);

  logic [NBITS_PC-1:0] r_pc;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pc <= '0;
    end else if (i_clr) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/bip_control.sv
// BIP control unit: FETCH/DECODE/EXEC sequencer driving program memory,
// data memory and accumulator datapath controls, with a saturating cycle counter.
module bip_control
  import bip_pkg::*;
#(
  parameter int NBITS_PC  = 11,
  parameter int NBITS_OPC = 5,
  parameter int NBITS_I   = 16,
  parameter int NBITS_CNT = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  bip_control_if.master        bus,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic [NBITS_CNT-1:0] o_ClkCount
);

  state_t                r_state, w_state_next;
  logic [NBITS_I-1:0]    r_ir;
  logic [NBITS_CNT-1:0]  r_cnt;
  logic [NBITS_PC-1:0]   w_pc;
  logic                  w_run_req;
  logic                  w_busy;
  logic [NBITS_OPC-1:0]  w_opc_dec, w_opc_ir;
  logic [NBITS_PC-1:0]   w_opnd_dec, w_opnd_ir;

  assign w_opc_dec  = bus.i_Instruction[NBITS_I-1 -: NBITS_OPC];
  assign w_opnd_dec = bus.i_Instruction[NBITS_PC-1:0];
  assign w_opc_ir   = r_ir[NBITS_I-1 -: NBITS_OPC];
  assign w_opnd_ir  = r_ir[NBITS_PC-1:0];

  assign w_run_req = ((r_state == ST_IDLE) || (r_state == ST_HALT)) && i_start;
  assign w_busy    = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);

  pc_counter #(.NBITS_PC(NBITS_PC)) u_pc (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (w_run_req),
    .i_inc   (r_state == ST_EXEC),
    .o_pc    (w_pc)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: w_state_next = (w_opc_dec == OPC_HLT) ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_state_next = ST_FETCH;
      ST_HALT:   if (i_start) w_state_next = ST_FETCH;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // HLT never reaches EXEC, so the IR only ever holds executable instructions.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ir <= '0;
    end else if ((r_state == ST_DECODE) && (w_opc_dec != OPC_HLT)) begin
      r_ir <= bus.i_Instruction;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_run_req) begin
      r_cnt <= '0;
    end else if (w_busy && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.o_SelA    = SELA_ALU;
    bus.o_SelB    = SELB_MEM;
    bus.o_Op      = OP_ADD;
    bus.o_WrAcc   = 1'b0;
    bus.o_WrRam   = 1'b0;
    bus.o_RdRam   = 1'b0;
    bus.o_Operand = '0;
    bus.o_Addr    = '0;
    // Read issued a cycle early so the sync RAM data lands in EXEC.
    if ((r_state == ST_DECODE) && is_mem_read(w_opc_dec)) begin
      bus.o_RdRam = 1'b1;
      bus.o_Addr  = w_opnd_dec;
    end
    if (r_state == ST_EXEC) begin
      case (w_opc_ir)
        OPC_LD: begin
          bus.o_RdRam = 1'b1;
          bus.o_Addr  = w_opnd_ir;
          bus.o_SelA  = SELA_MEM;
          bus.o_WrAcc = 1'b1;
        end
        OPC_LDI: begin
          bus.o_SelA    = SELA_IMM;
          bus.o_Operand = w_opnd_ir;
          bus.o_WrAcc   = 1'b1;
        end
        OPC_ADD, OPC_SUB: begin
          bus.o_RdRam = 1'b1;
          bus.o_Addr  = w_opnd_ir;
          bus.o_Op    = (w_opc_ir == OPC_SUB) ? OP_SUB : OP_ADD;
          bus.o_WrAcc = 1'b1;
        end
        OPC_ADDI, OPC_SUBI: begin
          bus.o_SelB    = SELB_IMM;
          bus.o_Operand = w_opnd_ir;
          bus.o_Op      = (w_opc_ir == OPC_SUBI) ? OP_SUB : OP_ADD;
          bus.o_WrAcc   = 1'b1;
        end
        OPC_STO: begin
          bus.o_SelB  = SELB_IMM;
          bus.o_WrRam = 1'b1;
          bus.o_Addr  = w_opnd_ir;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_PC   = w_pc;
  assign o_busy     = w_busy;
  assign o_halted   = (r_state == ST_HALT);
  assign o_ClkCount = r_cnt;

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control with a behavioural ROM, data RAM and
// accumulator datapath; the monitor pops expected events as the DUT emits them.
module tb_bip_control;
  import bip_pkg::*;

  typedef enum logic [1:0] {EV_RD, EV_WR, EV_ACC, EV_HALT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        o_busy, o_halted;
  logic [15:0] o_ClkCount;

  int checks = 0;
  int errors = 0;
  ev_t sb[$];

  bip_control_if #(.NBITS_PC(11), .NBITS_I(16)) bus ();

  bip_control dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_start    (i_start),
    .bus        (bus),
    .o_busy     (o_busy),
    .o_halted   (o_halted),
    .o_ClkCount (o_ClkCount)
  );

  always #5 clk = ~clk;

  // Behavioural memories and accumulator datapath
  logic [15:0] rom [0:2047];
  logic [15:0] ram [0:2047];
  logic [15:0] acc = 16'h0;
  logic [15:0] ram_rdata = 16'h0;
  logic [15:0] instr = 16'h0;
  logic [15:0] ext_op, opb, alu, mux;

  always_comb begin
    ext_op = {{5{bus.o_Operand[10]}}, bus.o_Operand};
    opb    = bus.o_SelB ? ext_op : ram_rdata;
    alu    = bus.o_Op ? (acc - opb) : (acc + opb);
    case (bus.o_SelA)
      2'd0:    mux = ram_rdata;
      2'd1:    mux = ext_op;
      default: mux = alu;
    endcase
  end

  assign bus.i_Instruction = instr;

  always @(posedge clk) begin
    instr <= rom[bus.o_PC];
    if (bus.o_WrAcc) acc <= mux;
    if (bus.o_WrRam) ram[bus.o_Addr] <= alu;
    if (bus.o_RdRam) ram_rdata <= ram[bus.o_Addr];
  end

  function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
    return {o, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got a=%0h b=%0h, none expected", k.name(), a, b);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL ev_%s: got a=%0h b=%0h, expected %s a=%0h b=%0h",
                 k.name(), a, b, e.kind.name(), e.a, e.b);
      end else begin
        $display("ev %s a=%0h b=%0h ok", k.name(), a, b);
      end
    end
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  initial begin
    logic prev_halted;
    prev_halted = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.o_RdRam) check_ev(EV_RD, 32'(bus.o_Addr), 32'h0);
        if (bus.o_WrRam) check_ev(EV_WR, 32'(bus.o_Addr), 32'(alu));
        if (bus.o_WrAcc) check_ev(EV_ACC, 32'(mux), 32'h0);
        if (o_halted && !prev_halted) check_ev(EV_HALT, 32'(bus.o_PC), 32'(o_ClkCount));
        if (bus.o_WrAcc && bus.o_WrRam) chk("wr_overlap", 32'h1, 32'h0);
      end
      prev_halted = o_halted;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = ins(5'd12, 11'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!o_halted && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("halt_timeout", 32'(o_halted), 32'h1);
  endtask

  task automatic drain(input string name);
    @(negedge clk); @(posedge clk); #1;
    chk(name, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) ram[i] = 16'h0;
    clear_rom();

    // Reset state
    #12;
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_halted", 32'(o_halted), 32'h0);
    chk("rst_pc", 32'(bus.o_PC), 32'h0);
    chk("rst_cnt", 32'(o_ClkCount), 32'h0);
    chk("rst_selA", 32'(bus.o_SelA), 32'(SELA_ALU));
    chk("rst_wr", 32'({bus.o_WrAcc, bus.o_WrRam, bus.o_RdRam}), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("idle_no_start", 32'(o_busy), 32'h0);

    // 1: LDI 5; ADDI 3; STO 10; HLT
    rom[0] = ins(OPC_LDI, 11'd5);
    rom[1] = ins(OPC_ADDI, 11'd3);
    rom[2] = ins(OPC_STO, 11'd10);
    rom[3] = ins(OPC_HLT, 11'd0);
    push(EV_ACC, 32'd5, 0);
    push(EV_ACC, 32'd8, 0);
    push(EV_WR, 32'd10, 32'd8);
    push(EV_HALT, 32'd3, 32'd11);
    pulse_start();
    wait_halt(60);
    drain("sb_empty_prog1");
    chk("ram10", 32'(ram[10]), 32'd8);

    // 2: mem[7]=20; LD 7; SUB 7; SUBI 1; HLT
    clear_rom();
    ram[7] = 16'd20;
    rom[0] = ins(OPC_LD, 11'd7);
    rom[1] = ins(OPC_SUB, 11'd7);
    rom[2] = ins(OPC_SUBI, 11'd1);
    rom[3] = ins(OPC_HLT, 11'd0);
    push(EV_RD, 32'd7, 0); push(EV_RD, 32'd7, 0); push(EV_ACC, 32'd20, 0);
    push(EV_RD, 32'd7, 0); push(EV_RD, 32'd7, 0); push(EV_ACC, 32'd0, 0);
    push(EV_ACC, 32'hFFFF, 0);
    push(EV_HALT, 32'd3, 32'd11);
    pulse_start();
    wait_halt(60);
    drain("sb_empty_prog2");
    chk("acc_final", 32'(acc), 32'hFFFF);

    // 3: NOP (opcode 12); HLT
    clear_rom();
    rom[1] = ins(OPC_HLT, 11'd0);
    push(EV_HALT, 32'd1, 32'd5);
    pulse_start();
    chk("nop_pc0", 32'(bus.o_PC), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("nop_pc1", 32'(bus.o_PC), 32'd1);
    wait_halt(20);
    drain("sb_empty_nop");

    // 4: all-NOP ROM, PC wraps 2047 -> 0, HLT placed at 1 after first pass
    clear_rom();
    push(EV_HALT, 32'd1, 32'd6149);
    pulse_start();
    n = 0;
    while (bus.o_PC != 11'd2047 && n < 7000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_2047", 32'(bus.o_PC), 32'd2047);
    rom[1] = ins(OPC_HLT, 11'd0);
    repeat (3) @(posedge clk);
    #1 chk("wrap_pc0", 32'(bus.o_PC), 32'd0);
    chk("wrap_busy", 32'(o_busy), 32'h1);
    wait_halt(20);
    drain("sb_empty_wrap");

    // 5: reset during EXEC of STO
    clear_rom();
    ram[4] = 16'h1234;
    rom[0] = ins(OPC_LDI, 11'd9);
    rom[1] = ins(OPC_STO, 11'd4);
    rom[2] = ins(OPC_HLT, 11'd0);
    push(EV_ACC, 32'd9, 0);
    pulse_start();
    n = 0;
    while (!bus.o_WrRam && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sto_exec_seen", 32'(bus.o_WrRam), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstx_wrram", 32'(bus.o_WrRam), 32'h0);
    chk("rstx_busy", 32'(o_busy), 32'h0);
    chk("rstx_defaults", 32'({bus.o_SelA, bus.o_SelB, bus.o_Op, bus.o_Addr}), 32'({2'd2, 1'b0, 1'b0, 11'd0}));
    chk("rstx_pc", 32'(bus.o_PC), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("rstx_no_run", 32'({o_busy, o_halted}), 32'h0);
    chk("rstx_ram4_kept", 32'(ram[4]), 32'h1234);
    chk("sb_empty_rstx", 32'(sb.size()), 32'h0);
    push(EV_ACC, 32'd9, 0);
    push(EV_WR, 32'd4, 32'd9);
    push(EV_HALT, 32'd2, 32'd8);
    pulse_start();
    wait_halt(40);
    drain("sb_empty_rerun");
    chk("ram4", 32'(ram[4]), 32'd9);

    // 6: start held high during run, then pulsed in HALT
    clear_rom();
    rom[0] = ins(OPC_LDI, 11'd1);
    rom[1] = ins(OPC_ADDI, 11'd2);
    rom[2] = ins(OPC_HLT, 11'd0);
    push(EV_ACC, 32'd1, 0);
    push(EV_ACC, 32'd3, 0);
    push(EV_HALT, 32'd2, 32'd8);
    @(posedge clk); #1 i_start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(o_busy && bus.o_PC == 11'd2) && n < 30);
    chk("held_reach_pc2", 32'(bus.o_PC), 32'd2);
    i_start = 1'b0;
    wait_halt(20);
    drain("sb_empty_held");
    repeat (3) @(posedge clk);
    #1 chk("halt_cnt_hold", 32'(o_ClkCount), 32'd8);
    chk("halt_pc_hold", 32'(bus.o_PC), 32'd2);
    push(EV_ACC, 32'd1, 0);
    push(EV_ACC, 32'd3, 0);
    push(EV_HALT, 32'd2, 32'd8);
    pulse_start();
    chk("restart_pc", 32'(bus.o_PC), 32'd0);
    chk("restart_cnt", 32'(o_ClkCount), 32'd0);
    chk("restart_busy", 32'(o_busy), 32'h1);
    wait_halt(40);
    drain("sb_empty_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
